// File: rtl/multiplier_pkg.sv
// Shared constants and types for the Barrett multiplier/reducer family.
// DATA_LENGTH must be even; the precompute rejects moduli wider than DATA_LENGTH/2.
package multiplier_pkg;

    localparam int DATA_LENGTH = 64;
    localparam int CNT_W       = $clog2(DATA_LENGTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        BITLEN,
        DIVIDE,
        DONE
    } precomp_state_t;

endpackage

// File: rtl/bitlen_enc.sv
// Combinational bit-length encoder: index of the most significant set bit plus one, 0 for zero.
module bitlen_enc
    import multiplier_pkg::*;
(
    input  logic [DATA_LENGTH-1:0] data_i,
    output logic [DATA_LENGTH-1:0] bitlen_o
);

    always_comb begin
        bitlen_o = '0;
        for (int i = 0; i < DATA_LENGTH; i++) begin
            if (data_i[i]) bitlen_o = DATA_LENGTH'(i + 1);
        end
    end

endmodule

// File: rtl/barrett_precomp_bs.sv
// Barrett constant precompute: k = bitlen(m), mu = floor(2^(2k)/m) by bit-serial
// restoring division, one quotient bit per cycle, presented with a one-cycle valid.
module barrett_precomp_bs
    import multiplier_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [DATA_LENGTH-1:0] m_i,
    output logic                   busy_o,
    output logic                   valid_o,
    output logic                   err_o,
    output logic [DATA_LENGTH-1:0] m_o,
    output logic [DATA_LENGTH-1:0] m_bl_o,
    output logic [DATA_LENGTH-1:0] mu_o
);

    localparam logic [DATA_LENGTH-1:0] K_MAX = DATA_LENGTH'(DATA_LENGTH / 2);

    precomp_state_t         state_q, state_d;
    logic [DATA_LENGTH-1:0] m_reg_q, m_reg_d;
    logic [DATA_LENGTH-1:0] k_q, k_d;
    logic                   err_q, err_d;
    logic [DATA_LENGTH:0]   rem_q, rem_d;
    logic [DATA_LENGTH-1:0] q_q, q_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   valid_q, valid_d;
    logic                   err_o_q, err_o_d;
    logic [DATA_LENGTH-1:0] m_o_q, m_o_d;
    logic [DATA_LENGTH-1:0] m_bl_q, m_bl_d;
    logic [DATA_LENGTH-1:0] mu_q, mu_d;

    logic [DATA_LENGTH-1:0] bl;
    logic [CNT_W-1:0]       two_k;
    logic [DATA_LENGTH:0]   t;
    logic                   ge;

    bitlen_enc u_bitlen (
        .data_i   (m_reg_q),
        .bitlen_o (bl)
    );

    // The single dividend 1-bit of 2^(2k) enters on the first DIVIDE cycle (cnt == 2k).
    assign two_k = {k_q[CNT_W-2:0], 1'b0};
    assign t     = (rem_q << 1) | {{DATA_LENGTH{1'b0}}, (cnt_q == two_k)};
    assign ge    = (t >= {1'b0, m_reg_q});

    always_comb begin
        state_d  = state_q;
        m_reg_d  = m_reg_q;
        k_d      = k_q;
        err_d    = err_q;
        rem_d    = rem_q;
        q_d      = q_q;
        cnt_d    = cnt_q;
        valid_d  = 1'b0;
        err_o_d  = err_o_q;
        m_o_d    = m_o_q;
        m_bl_d   = m_bl_q;
        mu_d     = mu_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    m_reg_d = m_i;
                    state_d = BITLEN;
                end
            end
            BITLEN: begin
                k_d     = bl;
                rem_d   = '0;
                q_d     = '0;
                state_d = DIVIDE;
                // Rejected moduli still spend one DIVIDE cycle so the result lands
                // after E0+2, the same timing as a k=0 division.
                if (m_reg_q == '0 || bl > K_MAX) begin
                    err_d = 1'b1;
                    cnt_d = '0;
                end else begin
                    err_d = 1'b0;
                    cnt_d = {bl[CNT_W-2:0], 1'b0};
                end
            end
            DIVIDE: begin
                rem_d = ge ? (t - {1'b0, m_reg_q}) : t;
                q_d   = {q_q[DATA_LENGTH-2:0], ge};
                if (cnt_q == '0) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    err_o_d = err_q;
                    m_o_d   = m_reg_q;
                    m_bl_d  = k_q;
                    mu_d    = err_q ? '0 : q_d;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            m_reg_q <= '0;
            k_q     <= '0;
            err_q   <= 1'b0;
            rem_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_o_q <= 1'b0;
            m_o_q   <= '0;
            m_bl_q  <= '0;
            mu_q    <= '0;
        end else begin
            state_q <= state_d;
            m_reg_q <= m_reg_d;
            k_q     <= k_d;
            err_q   <= err_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            err_o_q <= err_o_d;
            m_o_q   <= m_o_d;
            m_bl_q  <= m_bl_d;
            mu_q    <= mu_d;
        end
    end

    assign busy_o  = (state_q != IDLE);
    assign valid_o = valid_q;
    assign err_o   = err_o_q;
    assign m_o     = m_o_q;
    assign m_bl_o  = m_bl_q;
    assign mu_o    = mu_q;

endmodule

// File: tb/tb_barrett_precomp_bs.sv
// Randomized and directed bench for barrett_precomp_bs against an arithmetic reference.
module tb_barrett_precomp_bs;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [63:0] m_i = '0;
    logic        busy_o, valid_o, err_o;
    logic [63:0] m_o, m_bl_o, mu_o;

    int checks = 0;
    int errors = 0;

    barrett_precomp_bs dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (start_i),
        .m_i     (m_i),
        .busy_o  (busy_o),
        .valid_o (valid_o),
        .err_o   (err_o),
        .m_o     (m_o),
        .m_bl_o  (m_bl_o),
        .mu_o    (mu_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference: k = bit length, mu = floor(2^(2k)/m), reject m=0 or k>32.
    function automatic int ref_k(input logic [63:0] m);
        int k = 0;
        while (k < 64 && (m >> k) != 0) k++;
        return k;
    endfunction

    function automatic logic ref_err(input logic [63:0] m);
        return (m == 0) || (ref_k(m) > 32);
    endfunction

    function automatic logic [63:0] ref_mu(input logic [63:0] m);
        logic [128:0] num, q;
        if (ref_err(m)) return 64'd0;
        num = 129'd1 << (2 * ref_k(m));
        q = num / {65'd0, m};
        return q[63:0];
    endfunction

    task automatic check_result(input string nm, input logic [63:0] m);
        checks++;
        if (err_o !== ref_err(m)) begin
            errors++; $display("FAIL %s err: got %0b want %0b", nm, err_o, ref_err(m));
        end
        checks++;
        if (m_o !== m) begin
            errors++; $display("FAIL %s m_o: got %h want %h", nm, m_o, m);
        end
        checks++;
        if (m_bl_o !== 64'(ref_k(m))) begin
            errors++; $display("FAIL %s m_bl: got %0d want %0d", nm, m_bl_o, ref_k(m));
        end
        checks++;
        if (mu_o !== ref_mu(m)) begin
            errors++; $display("FAIL %s mu: got %h want %h", nm, mu_o, ref_mu(m));
        end
    endtask

    task automatic run_op(input logic [63:0] m, input string nm);
        int lat, n;
        bit seen;
        lat = ref_err(m) ? 2 : 2 * ref_k(m) + 2;
        @(negedge clk_i);
        m_i = m; start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1) begin
            errors++; $display("FAIL %s busy_after_start: got %b want 1", nm, busy_o);
        end
        n = 0; seen = 0;
        while (!seen && n < 200) begin
            @(posedge clk_i); n++; #1;
            if (valid_o === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || n != lat) begin
            errors++; $display("FAIL %s latency: got %0d (seen=%0b) want %0d", nm, n, seen, lat);
        end
        check_result(nm, m);
        @(posedge clk_i); #1;
        checks++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL %s after_done: valid=%b busy=%b want 0 0", nm, valid_o, busy_o);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if ({busy_o, valid_o, err_o} !== 3'b000 || m_o !== 0 || m_bl_o !== 0 || mu_o !== 0) begin
            errors++;
            $display("FAIL reset_state: busy=%b valid=%b err=%b m=%h bl=%h mu=%h want all 0",
                     busy_o, valid_o, err_o, m_o, m_bl_o, mu_o);
        end
        @(negedge clk_i) rst_ni = 1'b1;
        @(posedge clk_i); #1;
        checks++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: busy=%b valid=%b want 0 0", busy_o, valid_o);
        end
    endtask

    task automatic test_directed();
        run_op(64'd13, "m13");
        run_op(64'd1, "m1");
        run_op(64'hFFFF_FFFF, "m_ffffffff");
        checks++;
        if (mu_o !== 64'h1_0000_0001) begin
            errors++; $display("FAIL m_ffffffff_const: got %h want 100000001", mu_o);
        end
        run_op(64'd0, "m0");
        run_op(64'd1 << 33, "m2p33");
        checks++;
        if (m_bl_o !== 64'd34) begin
            errors++; $display("FAIL m2p33_bl_const: got %0d want 34", m_bl_o);
        end
        run_op(64'd1 << 31, "m2p31");
    endtask

    task automatic test_random();
        logic [63:0] mv, mask;
        int bits;
        for (int it = 0; it < 12; it++) begin
            bits = $urandom_range(0, 40);
            mv = {$urandom, $urandom};
            if (bits == 0) mv = '0;
            else begin
                mask = (64'd1 << bits) - 64'd1;
                mv = (mv & mask) | (64'd1 << (bits - 1));
            end
            run_op(mv, $sformatf("rand%0d", it));
        end
    endtask

    task automatic test_busy_ignore();
        int vat = -1;
        @(negedge clk_i);
        m_i = 64'd13; start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            @(posedge clk_i); #1;
            if (valid_o === 1'b1) begin
                if (vat < 0) vat = n;
                check_result("busy_ignore", 64'd13);
            end
            if (n < 8) begin
                start_i = ~start_i;
                m_i = {$urandom, $urandom};
            end else begin
                start_i = 1'b0;
            end
        end
        checks++;
        if (vat != 10) begin
            errors++; $display("FAIL busy_ignore_latency: got %0d want 10", vat);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL busy_ignore_restart: busy=%b want 0", busy_o);
        end
    endtask

    task automatic test_back_to_back();
        int nvalid = 0;
        int cyc;
        @(negedge clk_i);
        m_i = 64'd200; start_i = 1'b1;   // k=8, period 20
        for (int n = 0; n <= 70; n++) begin
            @(posedge clk_i); #1;
            if (valid_o === 1'b1) begin
                checks++;
                if (n != 18 + 20 * nvalid) begin
                    errors++; $display("FAIL b2b_spacing: valid at %0d want %0d", n, 18 + 20 * nvalid);
                end
                check_result("b2b", 64'd200);
                nvalid++;
            end
        end
        start_i = 1'b0;
        checks++;
        if (nvalid != 3) begin
            errors++; $display("FAIL b2b_count: got %0d want 3", nvalid);
        end
        cyc = 0;
        while (busy_o === 1'b1 && cyc < 100) begin
            @(posedge clk_i); #1; cyc++;
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL b2b_drain: busy=%b want 0", busy_o);
        end
    endtask

    task automatic test_reset_mid();
        int vcount = 0;
        @(negedge clk_i);
        m_i = 64'd13; start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #3 rst_ni = 1'b0;
        #1;
        checks++;
        if ({busy_o, valid_o, err_o} !== 3'b000 || m_o !== 0 || m_bl_o !== 0 || mu_o !== 0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b valid=%b err=%b m=%h bl=%h mu=%h want all 0",
                     busy_o, valid_o, err_o, m_o, m_bl_o, mu_o);
        end
        @(negedge clk_i) rst_ni = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk_i); #1;
            if (valid_o !== 1'b0 || busy_o !== 1'b0) vcount++;
        end
        checks++;
        if (vcount != 0) begin
            errors++; $display("FAIL reset_mid_quiet: %0d active cycles want 0", vcount);
        end
        run_op(64'd13, "after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
